// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: sequential PC generation, synchronous ROM reads, FWFT prefetch queue.
// Optional FETCH_STATS_EN adds saturating fetched/flushed statistics counters.
module fetch_queue_stage #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_INITIAL  = 0,
  parameter int PC_STEP     = 1,
  parameter int DEPTH       = 4
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   pc_chg,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   mem_en,
  output logic [PC_WIDTH-1:0]    mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  input  logic                   out_ready,
  output logic                   done,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [15:0]            stat_flushed
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;
  localparam logic [PC_WIDTH-1:0] PC_INIT_V = PC_WIDTH'(PC_INITIAL);
  localparam logic [PC_WIDTH-1:0] PC_STEP_V = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   inflight;
  logic [AW-1:0]          rd_ptr;
  logic [AW-1:0]          wr_ptr;
  logic [AW:0]            count;
  logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem   [DEPTH];
  logic [INSTR_WIDTH-1:0] last_instr;
  logic [PC_WIDTH-1:0]    last_pc;
  logic                   push;
  logic                   pop;

  // Credit counts the outstanding read as occupied, so a push can never overflow the queue.
  always_comb begin
    mem_en   = !pc_chg && ((CW'(count) + CW'(inflight)) < CW'(DEPTH));
    mem_addr = fetch_pc;
    done     = (count != '0);
    push     = inflight && !pc_chg;
    pop      = done && out_ready && !pc_chg;
    instr    = done ? data_mem[rd_ptr] : last_instr;
    pc_out   = done ? pc_mem[rd_ptr]   : last_pc;
  end

  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      fetch_pc   <= PC_INIT_V;
      req_pc     <= PC_INIT_V;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= PC_INIT_V + PC_STEP_V;
    end else if (pc_chg) begin
      fetch_pc <= pc_in;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= mem_en;
      if (mem_en) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP_V;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        last_instr <= instr;
        last_pc    <= pc_out;
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk_in) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_data;
      pc_mem[wr_ptr]   <= req_pc + PC_STEP_V;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop && (stat_fetched != '1)) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (pc_chg && ((count != '0) || inflight) && (stat_flushed != '1)) begin
        stat_flushed <= stat_flushed + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized self-checking bench for fetch_queue_stage against a queue-of-addresses reference model.
module tb_fetch_queue_stage;

  localparam int PW    = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          RST;
  logic          pc_chg;
  logic [PW-1:0] pc_in;
  logic          mem_en;
  logic [PW-1:0] mem_addr;
  logic [IW-1:0] mem_data = '0;
  logic          out_ready;
  logic          done;
  logic [IW-1:0] instr;
  logic [PW-1:0] pc_out;

  int checks = 0;
  int passes = 0;

  logic [PW-1:0] m_fetch;
  logic [PW-1:0] m_req;
  bit            m_inflight;
  logic [PW-1:0] mq[$];
  logic [IW-1:0] m_last_instr;
  logic [PW-1:0] m_last_pc;

  always #5 clk_in = ~clk_in;

  fetch_queue_stage #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .PC_INITIAL(0), .PC_STEP(1), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk_in), .RST(RST), .pc_chg(pc_chg), .pc_in(pc_in),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_ready(out_ready), .done(done), .instr(instr), .pc_out(pc_out)
  );

  function automatic logic [IW-1:0] rom(input logic [PW-1:0] a);
    return IW'(a) + 32'd100;
  endfunction

  // Synchronous program ROM: data appears the cycle after the enabled edge.
  always @(posedge clk_in) begin
    if (mem_en) mem_data <= rom(mem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input bit r, input bit c, input logic [PW-1:0] p);
    @(posedge clk_in);
    #1;
    out_ready = r;
    pc_chg    = c;
    pc_in     = p;
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so at the falling edge the model
  // both predicts current outputs and advances across the coming rising edge.
  always @(negedge clk_in) begin : model_blk
    bit            e_en;
    bit            e_done;
    logic [IW-1:0] e_instr;
    logic [PW-1:0] e_pc;
    if (!RST) begin
      m_fetch      = '0;
      m_req        = '0;
      m_inflight   = 1'b0;
      mq.delete();
      m_last_instr = '0;
      m_last_pc    = 16'd1;
    end else begin
      e_en    = !pc_chg && ((mq.size() + int'(m_inflight)) < DEPTH);
      e_done  = (mq.size() != 0);
      e_instr = e_done ? rom(mq[0]) : m_last_instr;
      e_pc    = e_done ? mq[0] + 16'd1 : m_last_pc;
      checkOutput("mem_en",   32'(mem_en),   32'(e_en));
      checkOutput("mem_addr", 32'(mem_addr), 32'(m_fetch));
      checkOutput("done",     32'(done),     32'(e_done));
      checkOutput("instr",    instr,         e_instr);
      checkOutput("pc_out",   32'(pc_out),   32'(e_pc));
      if (pc_chg) begin
        m_fetch    = pc_in;
        m_inflight = 1'b0;
        mq.delete();
      end else begin
        if (e_done && out_ready) begin
          m_last_instr = e_instr;
          m_last_pc    = e_pc;
          void'(mq.pop_front());
        end
        if (m_inflight) mq.push_back(m_req);
        m_inflight = e_en;
        if (e_en) begin
          m_req   = m_fetch;
          m_fetch = m_fetch + 16'd1;
        end
      end
    end
  end

  initial begin
    RST = 1'b0; pc_chg = 1'b0; pc_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    checkOutput("rst_done",   32'(done),     32'd0);
    checkOutput("rst_instr",  instr,         32'd0);
    checkOutput("rst_pc_out", 32'(pc_out),   32'd1);
    checkOutput("rst_addr",   32'(mem_addr), 32'd0);

    @(posedge clk_in);
    #1;
    RST = 1'b1; out_ready = 1'b1;
    @(negedge clk_in);
    checkOutput("first_en",   32'(mem_en),   32'd1);
    checkOutput("first_addr", 32'(mem_addr), 32'd0);
    @(negedge clk_in);
    checkOutput("e1_done", 32'(done),     32'd0);
    checkOutput("e1_addr", 32'(mem_addr), 32'd1);
    @(negedge clk_in);
    checkOutput("e2_done",  32'(done),   32'd1);
    checkOutput("e2_instr", instr,       32'd100);
    checkOutput("e2_pc",    32'(pc_out), 32'd1);
    @(negedge clk_in);
    checkOutput("e3_instr", instr,       32'd101);
    checkOutput("e3_pc",    32'(pc_out), 32'd2);

    // Stall the consumer until the queue fills.
    repeat (8) applyStimulus(1'b0, 1'b0, '0);
    @(negedge clk_in);
    checkOutput("full_en",   32'(mem_en), 32'd0);
    checkOutput("full_done", 32'(done),   32'd1);

    applyStimulus(1'b0, 1'b1, 16'h0040);
    applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk_in);
    checkOutput("redir_done", 32'(done),     32'd0);
    checkOutput("redir_addr", 32'(mem_addr), 32'h40);
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk_in);
    checkOutput("redir_instr", instr,       rom(16'h0040));
    checkOutput("redir_pc",    32'(pc_out), 32'h41);

    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk_in);
    checkOutput("wrap_instr", instr,       32'h0001_0063);
    checkOutput("wrap_pc",    32'(pc_out), 32'h0);
    applyStimulus(1'b1, 1'b0, '0);
    @(negedge clk_in);
    checkOutput("wrap_next_instr", instr,       32'd100);
    checkOutput("wrap_next_pc",    32'(pc_out), 32'd1);

    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 90 : 60);
      for (int i = 0; i < 200; i++) begin
        logic [PW-1:0] p;
        case ($urandom_range(0, 3))
          0:       p = 16'hFFFF;
          1:       p = 16'h0040;
          default: p = PW'($urandom);
        endcase
        applyStimulus($urandom_range(0, 99) < rdy_pct, $urandom_range(0, 24) == 0, p);
      end
    end

    // Asynchronous reset pulse between clock edges.
    applyStimulus(1'b1, 1'b0, '0);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("arst_done",  32'(done),   32'd0);
    checkOutput("arst_pc",    32'(pc_out), 32'd1);
    checkOutput("arst_instr", instr,       32'd0);
    @(posedge clk_in);
    #1;
    RST = 1'b1;
    for (int i = 0; i < 40; i++) applyStimulus($urandom_range(0, 1) == 1, 1'b0, '0);

    @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
